// File: rtl/av2_mv_reconstruct.sv
// av2_mv_reconstruct: rebuilds per-block MVs as delta + median(left, above, above-right) predictor.
// Optional AV2_MV_CLAMP_EN saturates the sum to +/-MV_LIMIT; otherwise the sum wraps to MV_W bits.
module av2_mv_reconstruct #(
    parameter int MV_W     = 16,
    parameter int MAX_COLS = 64,
    parameter int COL_W    = 6,
    parameter int MV_LIMIT = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [COL_W:0]          frame_cols,
    input  logic signed [MV_W-1:0]  delta_x,
    input  logic signed [MV_W-1:0]  delta_y,
    input  logic                    delta_valid,
    output logic                    delta_ready,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic                    mv_valid,
    input  logic                    mv_ready,
    output logic [COL_W-1:0]        col_idx,
    output logic [COL_W-1:0]        row_idx,
    output logic                    busy
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_AR, CALC, OUT} state_t;

    state_t state, state_nxt;
    logic frame_active, accept, hs, last_col;
    logic [COL_W:0] cols;
    logic [COL_W-1:0] col, row, rd_addr;
    logic signed [MV_W-1:0] dx, dy, lx, ly, ax, ay, arx, ary, px, py;
    logic signed [MV_W:0] sx, sy;
    logic [2*MV_W-1:0] lb [MAX_COLS];
    logic [2*MV_W-1:0] rd_data;

    function automatic logic signed [MV_W-1:0] med3(input logic signed [MV_W-1:0] a, b, c);
        logic signed [MV_W-1:0] lo, hi, m;
        lo = a < b ? a : b;
        hi = a < b ? b : a;
        m  = hi < c ? hi : c;
        return lo > m ? lo : m;
    endfunction

    function automatic logic signed [MV_W-1:0] resolve(input logic signed [MV_W:0] s);
`ifdef AV2_MV_CLAMP_EN
        logic signed [MV_W:0] lim;
        lim = (MV_W+1)'(MV_LIMIT);
        return s > lim ? MV_W'(lim) : s < -lim ? MV_W'(-lim) : MV_W'(s);
`else
        return MV_W'(s);
`endif
    endfunction

    assign accept   = delta_valid && delta_ready;
    assign hs       = state == OUT && mv_ready && !frame_start;
    assign last_col = {1'b0, col} == cols - (COL_W+1)'(1);
    assign col_idx  = col;
    assign row_idx  = row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = frame_start     ? IDLE :
                    state == IDLE   ? (accept ? RD_A : IDLE) :
                    state == RD_A   ? RD_AR :
                    state == RD_AR  ? CALC :
                    state == CALC   ? OUT :
                    (mv_ready ? IDLE : OUT);
    end

    always_comb begin
        delta_ready = state == IDLE && frame_active && !frame_start;
        busy        = state != IDLE;
    end

    // Two-stage read: address registered, then data registered, so RD_AR sees lb[col] and CALC sees lb[col+1].
    always_ff @(posedge clk) begin
        rd_addr <= state == RD_A ? col + COL_W'(1) : col;
        rd_data <= lb[rd_addr];
        if (hs) lb[col] <= {mv_y, mv_x};
    end

    always_comb begin
        arx = (row == '0 || last_col) ? ax : rd_data[MV_W-1:0];
        ary = (row == '0 || last_col) ? ay : rd_data[2*MV_W-1:MV_W];
        px  = med3(lx, ax, arx);
        py  = med3(ly, ay, ary);
        sx  = {dx[MV_W-1], dx} + {px[MV_W-1], px};
        sy  = {dy[MV_W-1], dy} + {py[MV_W-1], py};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_x         <= '0;
            mv_y         <= '0;
            mv_valid     <= 1'b0;
            col          <= '0;
            row          <= '0;
            lx           <= '0;
            ly           <= '0;
            ax           <= '0;
            ay           <= '0;
            dx           <= '0;
            dy           <= '0;
            frame_active <= 1'b0;
            cols         <= (COL_W+1)'(MAX_COLS);
        end else if (frame_start) begin
            mv_valid     <= 1'b0;
            col          <= '0;
            row          <= '0;
            lx           <= '0;
            ly           <= '0;
            frame_active <= 1'b1;
            cols         <= (frame_cols == '0 || frame_cols > (COL_W+1)'(MAX_COLS)) ?
                            (COL_W+1)'(MAX_COLS) : frame_cols;
        end else begin
            if (accept) begin
                dx <= delta_x;
                dy <= delta_y;
            end
            if (state == RD_AR) begin
                ax <= row == '0 ? '0 : rd_data[MV_W-1:0];
                ay <= row == '0 ? '0 : rd_data[2*MV_W-1:MV_W];
            end
            if (state == CALC) begin
                mv_x     <= resolve(sx);
                mv_y     <= resolve(sy);
                mv_valid <= 1'b1;
            end
            if (hs) begin
                mv_valid <= 1'b0;
                lx       <= last_col ? '0 : mv_x;
                ly       <= last_col ? '0 : mv_y;
                col      <= last_col ? '0 : col + COL_W'(1);
                row      <= last_col ? row + COL_W'(1) : row;
            end
        end
    end
endmodule

// File: tb/tb_av2_mv_reconstruct.sv
// tb_av2_mv_reconstruct: scoreboard bench for the MV reconstruction block.
module tb_av2_mv_reconstruct;
    logic clk = 0, rst = 1, frame_start = 0, delta_valid = 0, mv_ready = 0;
    logic [6:0] frame_cols = 0;
    logic signed [15:0] delta_x = 0, delta_y = 0;
    logic delta_ready, mv_valid, busy;
    logic signed [15:0] mv_x, mv_y;
    logic [5:0] col_idx, row_idx;

    int vectors = 0, errors = 0;
    logic [31:0] q[$];
    int m_lbx[64], m_lby[64];
    int m_lx = 0, m_ly = 0, m_col = 0, m_row = 0, m_cols = 64;

    av2_mv_reconstruct dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_cols(frame_cols),
        .delta_x(delta_x), .delta_y(delta_y), .delta_valid(delta_valid), .delta_ready(delta_ready),
        .mv_x(mv_x), .mv_y(mv_y), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .col_idx(col_idx), .row_idx(row_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int med(int a, int b, int c);
        int mx, mn;
        mx = a > b ? a : b;
        mx = mx > c ? mx : c;
        mn = a < b ? a : b;
        mn = mn < c ? mn : c;
        return a + b + c - mx - mn;
    endfunction

    function automatic logic signed [15:0] fix(int s);
`ifdef AV2_MV_CLAMP_EN
        return 16'(s > 4095 ? 4095 : s < -4095 ? -4095 : s);
`else
        return 16'(s);
`endif
    endfunction

    // Reference model: predicts at accept, commits neighbour state at handshake.
    always @(negedge clk) begin
        if (rst) q.delete();
        else if (frame_start) begin
            q.delete();
            m_col = 0; m_row = 0; m_lx = 0; m_ly = 0;
            m_cols = (frame_cols == 0 || frame_cols > 64) ? 64 : int'(frame_cols);
        end else begin
            if (delta_valid && delta_ready) begin
                int lx, ly, ax, ay, arx, ary;
                logic signed [15:0] ex, ey;
                lx = m_col == 0 ? 0 : m_lx;
                ly = m_col == 0 ? 0 : m_ly;
                ax = m_row == 0 ? 0 : m_lbx[m_col];
                ay = m_row == 0 ? 0 : m_lby[m_col];
                arx = (m_row == 0 || m_col == m_cols - 1) ? ax : m_lbx[m_col + 1];
                ary = (m_row == 0 || m_col == m_cols - 1) ? ay : m_lby[m_col + 1];
                ex = fix(int'(delta_x) + med(lx, ax, arx));
                ey = fix(int'(delta_y) + med(ly, ay, ary));
                q.push_back({ex, ey});
            end
            if (mv_valid && mv_ready) begin
                logic [31:0] e;
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got mv=(%0d,%0d), expected no output", mv_x, mv_y);
                end else begin
                    e = q.pop_front();
                    if ({mv_x, mv_y} !== e) begin
                        errors++;
                        $display("FAIL sb_mv: got (%0d,%0d), expected (%0d,%0d)", mv_x, mv_y,
                                 $signed(e[31:16]), $signed(e[15:0]));
                    end
                    m_lbx[m_col] = $signed(e[31:16]);
                    m_lby[m_col] = $signed(e[15:0]);
                    m_lx = $signed(e[31:16]);
                    m_ly = $signed(e[15:0]);
                    if (m_col == m_cols - 1) begin
                        m_col = 0; m_lx = 0; m_ly = 0; m_row = (m_row + 1) % 64;
                    end else m_col++;
                end
            end
        end
    end

    task automatic start_frame(input int c);
        @(posedge clk); #1 frame_start = 1; frame_cols = 7'(c);
        @(posedge clk); #1 frame_start = 0;
    endtask

    task automatic accept_delta(input logic signed [15:0] x, input logic signed [15:0] y);
        int n = 0;
        @(posedge clk); #1 delta_x = x; delta_y = y; delta_valid = 1;
        @(negedge clk);
        while (!delta_ready && n < 20) begin @(negedge clk); n++; end
        if (!delta_ready) begin
            vectors++; errors++;
            $display("FAIL accept_timeout: delta_ready=%b, expected 1 within 20 cycles", delta_ready);
        end
        @(posedge clk); #1 delta_valid = 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!mv_valid && lat < 20) begin @(posedge clk); #1 lat++; end
    endtask

    task automatic release_mv();
        mv_ready = 1;
        @(posedge clk); #1 mv_ready = 0;
    endtask

    task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, input int hold, output int lat);
        accept_delta(x, y);
        wait_valid(lat);
        repeat (hold) @(posedge clk);
        if (hold > 0) #1;
        release_mv();
    endtask

    task automatic test_reset();
        delta_valid = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mv_x, mv_y, mv_valid, delta_ready, col_idx, row_idx, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: mv=(%0d,%0d) v=%b rdy=%b col=%0d row=%0d busy=%b, expected all 0",
                     mv_x, mv_y, mv_valid, delta_ready, col_idx, row_idx, busy);
        end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        vectors++;
        if (delta_ready !== 0) begin
            errors++;
            $display("FAIL reset_no_frame: delta_ready=%b, expected 0", delta_ready);
        end
        delta_valid = 0;
    endtask

    task automatic test_basic();
        int lat;
        start_frame(4);
        accept_delta(16'sd5, -16'sd3);
        wait_valid(lat);
        vectors++;
        if (lat !== 3 || mv_x !== 16'sd5 || mv_y !== -16'sd3) begin
            errors++;
            $display("FAIL basic_first: lat=%0d mv=(%0d,%0d), expected lat=3 mv=(5,-3)", lat, mv_x, mv_y);
        end
        release_mv();
        vectors++;
        if (col_idx !== 6'd1 || busy !== 0) begin
            errors++;
            $display("FAIL basic_advance: col=%0d busy=%b, expected col=1 busy=0", col_idx, busy);
        end
        accept_delta(16'sd2, 16'sd2);
        wait_valid(lat);
        vectors++;
        if (mv_x !== 16'sd2 || mv_y !== 16'sd2) begin
            errors++;
            $display("FAIL basic_left_median: mv=(%0d,%0d), expected (2,2)", mv_x, mv_y);
        end
        release_mv();
    endtask

    task automatic test_median();
        int lat;
        start_frame(2);
        send(16'sd10, 16'sd10, 0, lat);
        send(16'sd20, -16'sd4, 1, lat);
        vectors++;
        if (row_idx !== 6'd1 || col_idx !== 6'd0) begin
            errors++;
            $display("FAIL median_wrap: row=%0d col=%0d, expected row=1 col=0", row_idx, col_idx);
        end
        accept_delta(16'sd1, 16'sd1);
        wait_valid(lat);
        vectors++;
        if (mv_x !== 16'sd11 || mv_y !== 16'sd1) begin
            errors++;
            $display("FAIL median_row1: mv=(%0d,%0d), expected (11,1)", mv_x, mv_y);
        end
        release_mv();
    endtask

    task automatic test_clamp();
        int lat;
        logic signed [15:0] ex, ey;
`ifdef AV2_MV_CLAMP_EN
        ex = 16'sd4095; ey = -16'sd4095;
`else
        ex = 16'sd4200; ey = -16'sd4200;
`endif
        start_frame(1);
        send(16'sd4000, -16'sd4000, 0, lat);
        accept_delta(16'sd200, -16'sd200);
        wait_valid(lat);
        vectors++;
        if (mv_x !== ex || mv_y !== ey || row_idx !== 6'd1) begin
            errors++;
            $display("FAIL clamp_sum: mv=(%0d,%0d) row=%0d, expected (%0d,%0d) row=1", mv_x, mv_y, row_idx, ex, ey);
        end
        release_mv();
    endtask

    task automatic test_stall();
        int lat;
        logic signed [15:0] sx, sy;
        logic [5:0] c0;
        start_frame(4);
        accept_delta(-16'sd9, 16'sd6);
        wait_valid(lat);
        sx = mv_x; sy = mv_y; c0 = col_idx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (mv_x !== sx || mv_y !== sy || mv_valid !== 1 || delta_ready !== 0 || col_idx !== c0) begin
                errors++;
                $display("FAIL stall_hold: cyc=%0d mv=(%0d,%0d) v=%b rdy=%b col=%0d, expected (%0d,%0d) v=1 rdy=0 col=%0d",
                         i, mv_x, mv_y, mv_valid, delta_ready, col_idx, sx, sy, c0);
            end
        end
        @(posedge clk); #1 release_mv();
        vectors++;
        if (busy !== 0 || mv_valid !== 0 || col_idx !== 6'd1) begin
            errors++;
            $display("FAIL stall_release: busy=%b v=%b col=%0d, expected 0 0 1", busy, mv_valid, col_idx);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_frame(5);
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom_range(0, 600)) - 16'sd300, 16'($urandom_range(0, 600)) - 16'sd300,
                 int'($urandom_range(0, 2)), lat);
            vectors++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL b2b_latency: blk=%0d lat=%0d, expected 3", i, lat);
            end
        end
    endtask

    task automatic test_abort();
        int lat;
        start_frame(4);
        send(16'sd1, 16'sd1, 0, lat);
        accept_delta(16'sd30, 16'sd30);
        @(posedge clk); #1;
        @(posedge clk); #1 frame_start = 1; frame_cols = 7'd4;
        @(posedge clk); #1 frame_start = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (mv_valid !== 0 || col_idx !== 0 || row_idx !== 0) begin
                errors++;
                $display("FAIL abort_drop: v=%b col=%0d row=%0d, expected 0 0 0", mv_valid, col_idx, row_idx);
            end
        end
        accept_delta(16'sd7, 16'sd7);
        wait_valid(lat);
        vectors++;
        if (mv_x !== 16'sd7 || mv_y !== 16'sd7) begin
            errors++;
            $display("FAIL abort_restart: mv=(%0d,%0d), expected (7,7)", mv_x, mv_y);
        end
        release_mv();
        accept_delta(16'sd3, 16'sd3);
        rst = 1; #1;
        vectors++;
        if ({mv_x, mv_y, mv_valid, delta_ready, col_idx, row_idx, busy} !== '0) begin
            errors++;
            $display("FAIL async_rst: mv=(%0d,%0d) v=%b rdy=%b col=%0d row=%0d busy=%b, expected all 0",
                     mv_x, mv_y, mv_valid, delta_ready, col_idx, row_idx, busy);
        end
        @(posedge clk); #1 rst = 0; delta_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (delta_ready !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL rst_inactive: rdy=%b busy=%b, expected 0 0", delta_ready, busy);
            end
        end
        delta_valid = 0;
        start_frame(3);
        send(-16'sd12, 16'sd8, 0, lat);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_median();
        test_clamp();
        test_stall();
        test_back_to_back();
        test_abort();
        repeat (3) @(posedge clk);
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected MVs never produced, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
